ball_engine: RTL and testbench

//  Parametrised ball for the VGA pong datapath: position, speed, wall bounce, paddle-hit reversal,

---
 rtl/ball_engine.sv | 167 ++++++++++++++++
 tb/tb_ball_engine.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_engine.sv
// Pong ball: per-frame position/direction update, wall bounce, paddle-hit reversal,
// miss detection and the serve state machine, plus the ball pixel decode.
module ball_engine #(
    parameter int p_H_VISIBLE   = 640,
    parameter int p_V_VISIBLE   = 480,
    parameter int p_SIZE        = 10,
    parameter int p_SPEED       = 1,
    parameter int p_SERVE_DELAY = 60,
    parameter int p_TICK_LINE   = 481
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [9:0] i_HSync_Pos,
    input  logic [9:0] i_VSync_Pos,
    input  logic       i_Hit,
    input  logic       i_Enable,
    output logic       o_Video,
    output logic       o_Miss_Left,
    output logic       o_Miss_Right,
    output logic       o_Serving
);

    localparam logic signed [10:0] X_CENTRE = 11'((p_H_VISIBLE - p_SIZE) / 2);
    localparam logic signed [10:0] Y_CENTRE = 11'((p_V_VISIBLE - p_SIZE) / 2);
    localparam logic signed [10:0] X_MAX    = 11'(p_H_VISIBLE - p_SIZE);
    localparam logic signed [10:0] Y_MAX    = 11'(p_V_VISIBLE - p_SIZE);
    localparam logic signed [10:0] SPEED    = 11'(p_SPEED);
    localparam logic signed [10:0] SIZE     = 11'(p_SIZE);

    typedef enum logic [1:0] {
        S_CENTRE,
        S_WAIT,
        S_PLAY,
        S_MISS
    } state_t;

    state_t             state_q, state_d;
    logic signed [10:0] x_q, x_d;
    logic signed [10:0] y_q, y_d;
    logic               xdir_q, xdir_d;
    logic               ydir_q, ydir_d;
    logic [7:0]         delay_q, delay_d;
    logic               hit_q, hit_d;
    logic               miss_left_q, miss_left_d;
    logic               miss_right_q, miss_right_d;

    logic               tick;
    logic               hit_now;
    logic               xdir_n;
    logic signed [10:0] x_next;
    logic signed [10:0] y_next;
    logic [7:0]         delay_inc;
    logic signed [10:0] h_pos;
    logic signed [10:0] v_pos;

    function automatic logic signed [10:0] sat_y(input logic signed [10:0] v);
        if (v <= 11'sd0)
            return 11'sd0;
        else if (v >= Y_MAX)
            return Y_MAX;
        else
            return v;
    endfunction

    assign tick      = (i_VSync_Pos == 10'(p_TICK_LINE)) && (i_HSync_Pos == 10'd0);
    // A hit arriving on the tick cycle itself must still count this frame.
    assign hit_now   = hit_q | i_Hit;
    assign xdir_n    = xdir_q ^ hit_now;
    assign x_next    = xdir_n ? (x_q + SPEED) : (x_q - SPEED);
    assign y_next    = ydir_q ? (y_q + SPEED) : (y_q - SPEED);
    assign delay_inc = delay_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        xdir_d       = xdir_q;
        ydir_d       = ydir_q;
        delay_d      = delay_q;
        hit_d        = hit_now;
        miss_left_d  = 1'b0;
        miss_right_d = 1'b0;
        if (tick) begin
            hit_d = 1'b0;
            if (i_Enable) begin
                case (state_q)
                    S_CENTRE: begin
                        x_d     = X_CENTRE;
                        y_d     = Y_CENTRE;
                        delay_d = 8'd0;
                        state_d = S_WAIT;
                    end
                    S_WAIT: begin
                        delay_d = delay_inc;
                        if (delay_inc == 8'(p_SERVE_DELAY))
                            state_d = S_PLAY;
                    end
                    S_PLAY: begin
                        xdir_d = xdir_n;
                        y_d    = sat_y(y_next);
                        if (y_next <= 11'sd0)
                            ydir_d = 1'b1;
                        else if (y_next >= Y_MAX)
                            ydir_d = 1'b0;
                        // xdir_d on a miss is the direction of the next serve
                        if (x_next < 11'sd0) begin
                            x_d         = 11'sd0;
                            xdir_d      = 1'b0;
                            miss_left_d = 1'b1;
                            state_d     = S_MISS;
                        end else if (x_next > X_MAX) begin
                            x_d          = X_MAX;
                            xdir_d       = 1'b1;
                            miss_right_d = 1'b1;
                            state_d      = S_MISS;
                        end else begin
                            x_d = x_next;
                        end
                    end
                    S_MISS: begin
                        x_d     = X_CENTRE;
                        y_d     = Y_CENTRE;
                        state_d = S_CENTRE;
                    end
                    default: state_d = S_CENTRE;
                endcase
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q      <= S_CENTRE;
            x_q          <= X_CENTRE;
            y_q          <= Y_CENTRE;
            xdir_q       <= 1'b1;
            ydir_q       <= 1'b1;
            delay_q      <= 8'd0;
            hit_q        <= 1'b0;
            miss_left_q  <= 1'b0;
            miss_right_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            xdir_q       <= xdir_d;
            ydir_q       <= ydir_d;
            delay_q      <= delay_d;
            hit_q        <= hit_d;
            miss_left_q  <= miss_left_d;
            miss_right_q <= miss_right_d;
        end
    end

    assign h_pos = signed'({1'b0, i_HSync_Pos});
    assign v_pos = signed'({1'b0, i_VSync_Pos});

    // Ball blanks for the single MISS frame.
    assign o_Video = (state_q != S_MISS) &&
                     (h_pos >= x_q) && (h_pos < x_q + SIZE) &&
                     (v_pos >= y_q) && (v_pos < y_q + SIZE);

    assign o_Miss_Left  = miss_left_q;
    assign o_Miss_Right = miss_right_q;
    assign o_Serving    = (state_q == S_CENTRE) || (state_q == S_WAIT);

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: three instances with different speed/serve settings,
// frame ticks driven directly on the position inputs, ball located by probing o_Video.
module tb_ball_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       hit;
    logic       en;
    logic [9:0] hpos;
    logic [9:0] vpos;

    logic vid_a, ml_a, mr_a, srv_a;
    logic vid_b, ml_b, mr_b, srv_b;
    logic vid_c, ml_c, mr_c, srv_c;
    logic vid_s, ml_s, mr_s, srv_s;
    int   sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ball_engine #(.p_SPEED(1), .p_SERVE_DELAY(3)) dut_a (
        .i_Clk(clk), .i_Reset(rst), .i_HSync_Pos(hpos), .i_VSync_Pos(vpos),
        .i_Hit(hit), .i_Enable(en), .o_Video(vid_a), .o_Miss_Left(ml_a),
        .o_Miss_Right(mr_a), .o_Serving(srv_a)
    );

    ball_engine #(.p_SPEED(3), .p_SERVE_DELAY(1)) dut_b (
        .i_Clk(clk), .i_Reset(rst), .i_HSync_Pos(hpos), .i_VSync_Pos(vpos),
        .i_Hit(hit), .i_Enable(en), .o_Video(vid_b), .o_Miss_Left(ml_b),
        .o_Miss_Right(mr_b), .o_Serving(srv_b)
    );

    ball_engine #(.p_SPEED(2), .p_SERVE_DELAY(1)) dut_c (
        .i_Clk(clk), .i_Reset(rst), .i_HSync_Pos(hpos), .i_VSync_Pos(vpos),
        .i_Hit(hit), .i_Enable(en), .o_Video(vid_c), .o_Miss_Left(ml_c),
        .o_Miss_Right(mr_c), .o_Serving(srv_c)
    );

    always_comb begin
        case (sel)
            0:       begin vid_s = vid_a; ml_s = ml_a; mr_s = mr_a; srv_s = srv_a; end
            1:       begin vid_s = vid_b; ml_s = ml_b; mr_s = mr_b; srv_s = srv_b; end
            default: begin vid_s = vid_c; ml_s = ml_c; mr_s = mr_c; srv_s = srv_c; end
        endcase
    end

    task automatic idle_pos();
        hpos = 10'd5;
        vpos = 10'd490;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; hpos = 10'd50; vpos = 10'd100;
        @(negedge clk);
        rst = 1'b0; idle_pos();
    endtask

    // One frame tick; miss outputs sampled on the cycle after the tick edge and the one after.
    task automatic do_tick(input logic with_hit, output logic ml1, output logic mr1,
                           output logic ml2, output logic mr2);
        @(negedge clk);
        hpos = 10'd0; vpos = 10'd481; hit = with_hit;
        @(posedge clk);
        #1;
        ml1 = ml_s; mr1 = mr_s;
        idle_pos(); hit = 1'b0;
        @(posedge clk);
        #1;
        ml2 = ml_s; mr2 = mr_s;
    endtask

    task automatic run_ticks(input int n);
        logic a, b, c, d;
        for (int i = 0; i < n; i++) do_tick(1'b0, a, b, c, d);
    endtask

    task automatic hit_pulse();
        @(negedge clk);
        hpos = 10'd50; vpos = 10'd100; hit = 1'b1;
        @(negedge clk);
        hit = 1'b0; idle_pos();
    endtask

    // Locate the ball bounding box on the selected instance; mx = -1 when nothing is drawn.
    task automatic measure(output int mx, output int my, output int mw, output int mh);
        int  h0, v0, e;
        bit  found;
        found = 1'b0; h0 = 0; v0 = 0; mx = -1; my = -1; mw = 0; mh = 0;
        for (int v = 0; v < 480; v += 5) begin
            for (int h = 0; h < 640; h += 5) begin
                if (!found) begin
                    hpos = 10'(h); vpos = 10'(v); #1;
                    if (vid_s) begin found = 1'b1; h0 = h; v0 = v; end
                end
            end
        end
        if (found) begin
            mx = h0; vpos = 10'(v0);
            while (mx > 0) begin
                hpos = 10'(mx - 1); #1;
                if (!vid_s) break;
                mx--;
            end
            e = h0;
            while (e < 639) begin
                hpos = 10'(e + 1); #1;
                if (!vid_s) break;
                e++;
            end
            mw = e - mx + 1;
            my = v0; hpos = 10'(h0);
            while (my > 0) begin
                vpos = 10'(my - 1); #1;
                if (!vid_s) break;
                my--;
            end
            e = v0;
            while (e < 479) begin
                vpos = 10'(e + 1); #1;
                if (!vid_s) break;
                e++;
            end
            mh = e - my + 1;
        end
        idle_pos();
    endtask

    task automatic test_reset();
        int x, y, w, h;
        sel = 0; en = 1'b1;
        do_reset();
        run_ticks(5);
        @(negedge clk);
        rst = 1'b1; hpos = 10'd200; vpos = 10'd300;
        @(negedge clk);
        rst = 1'b0; idle_pos();
        #1;
        total++; if (srv_s !== 1'b1) begin bad++; $display("FAIL reset_serving: got %b want 1", srv_s); end
        total++; if (ml_s !== 1'b0) begin bad++; $display("FAIL reset_miss_left: got %b want 0", ml_s); end
        total++; if (mr_s !== 1'b0) begin bad++; $display("FAIL reset_miss_right: got %b want 0", mr_s); end
        measure(x, y, w, h);
        total++; if (x !== 315) begin bad++; $display("FAIL reset_x: got %0d want 315", x); end
        total++; if (y !== 235) begin bad++; $display("FAIL reset_y: got %0d want 235", y); end
        total++; if (w !== 10) begin bad++; $display("FAIL reset_width: got %0d want 10", w); end
        total++; if (h !== 10) begin bad++; $display("FAIL reset_height: got %0d want 10", h); end
        // reset asserted on the tick cycle must win over the tick
        run_ticks(5);
        @(negedge clk);
        rst = 1'b1; hpos = 10'd0; vpos = 10'd481;
        @(negedge clk);
        rst = 1'b0; idle_pos();
        measure(x, y, w, h);
        total++; if (x !== 315) begin bad++; $display("FAIL reset_on_tick_x: got %0d want 315", x); end
        total++; if (y !== 235) begin bad++; $display("FAIL reset_on_tick_y: got %0d want 235", y); end
        total++; if (srv_s !== 1'b1) begin bad++; $display("FAIL reset_on_tick_serving: got %b want 1", srv_s); end
    endtask

    task automatic test_serve_delay();
        int   x, y, w, h;
        logic a, b, c, d;
        sel = 0; en = 1'b1;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            do_tick(1'b0, a, b, c, d);
            measure(x, y, w, h);
            total++; if (x !== 315) begin bad++; $display("FAIL serve_static_x tick %0d: got %0d want 315", i, x); end
            total++; if (y !== 235) begin bad++; $display("FAIL serve_static_y tick %0d: got %0d want 235", i, y); end
            total++; if (srv_s !== (i < 4)) begin bad++; $display("FAIL serve_serving tick %0d: got %b want %b", i, srv_s, (i < 4)); end
        end
        do_tick(1'b0, a, b, c, d);
        measure(x, y, w, h);
        total++; if (x !== 316) begin bad++; $display("FAIL serve_first_move_x: got %0d want 316", x); end
        total++; if (y !== 236) begin bad++; $display("FAIL serve_first_move_y: got %0d want 236", y); end
    endtask

    task automatic test_bounce();
        int x, y, w, h;
        sel = 1; en = 1'b1;
        do_reset();
        run_ticks(2 + 78);
        measure(x, y, w, h);
        total++; if (y !== 469) begin bad++; $display("FAIL bounce_pre_y: got %0d want 469", y); end
        total++; if (x !== 549) begin bad++; $display("FAIL bounce_pre_x: got %0d want 549", x); end
        run_ticks(1);
        measure(x, y, w, h);
        total++; if (y !== 470) begin bad++; $display("FAIL bounce_clamp_y: got %0d want 470", y); end
        total++; if (x !== 552) begin bad++; $display("FAIL bounce_clamp_x: got %0d want 552", x); end
        run_ticks(1);
        measure(x, y, w, h);
        total++; if (y !== 467) begin bad++; $display("FAIL bounce_up_y: got %0d want 467", y); end
    endtask

    task automatic test_miss_right();
        int   x, y, w, h;
        logic l1, r1, l2, r2;
        sel = 1;
        run_ticks(24);
        do_tick(1'b0, l1, r1, l2, r2);
        measure(x, y, w, h);
        total++; if (x !== 630) begin bad++; $display("FAIL edge_x: got %0d want 630", x); end
        total++; if (r1 !== 1'b0) begin bad++; $display("FAIL edge_no_miss: got %b want 0", r1); end
        do_tick(1'b0, l1, r1, l2, r2);
        total++; if (r1 !== 1'b1) begin bad++; $display("FAIL miss_right_pulse: got %b want 1", r1); end
        total++; if (r2 !== 1'b0) begin bad++; $display("FAIL miss_right_one_cycle: got %b want 0", r2); end
        total++; if (l1 !== 1'b0) begin bad++; $display("FAIL miss_right_left_quiet: got %b want 0", l1); end
        measure(x, y, w, h);
        total++; if (x !== -1) begin bad++; $display("FAIL miss_right_blank: got x %0d want -1", x); end
        run_ticks(1);
        total++; if (srv_s !== 1'b1) begin bad++; $display("FAIL miss_right_centre_serving: got %b want 1", srv_s); end
        run_ticks(1);
        measure(x, y, w, h);
        total++; if (x !== 315 || y !== 235) begin bad++; $display("FAIL miss_right_centre_pos: got %0d,%0d want 315,235", x, y); end
        run_ticks(2);
        measure(x, y, w, h);
        total++; if (x !== 318) begin bad++; $display("FAIL miss_right_serve_dir: got %0d want 318", x); end
    endtask

    task automatic test_hit();
        int   x, y, w, h;
        logic a, b, c, d;
        sel = 0; en = 1'b1;
        do_reset();
        run_ticks(5);
        hit_pulse();
        hit_pulse();
        run_ticks(1);
        measure(x, y, w, h);
        total++; if (x !== 315) begin bad++; $display("FAIL hit_reverse_x: got %0d want 315", x); end
        total++; if (y !== 237) begin bad++; $display("FAIL hit_reverse_y: got %0d want 237", y); end
        run_ticks(1);
        measure(x, y, w, h);
        total++; if (x !== 314) begin bad++; $display("FAIL hit_single_reverse_x: got %0d want 314", x); end
        do_tick(1'b1, a, b, c, d);
        measure(x, y, w, h);
        total++; if (x !== 315) begin bad++; $display("FAIL hit_on_tick_x: got %0d want 315", x); end
        run_ticks(1);
        measure(x, y, w, h);
        total++; if (x !== 316 || y !== 240) begin bad++; $display("FAIL hit_latch_cleared: got %0d,%0d want 316,240", x, y); end
    endtask

    task automatic test_pause();
        int   x, y, w, h;
        logic a, b, c, d;
        sel = 0;
        en = 1'b0;
        run_ticks(4);
        hit_pulse();
        do_tick(1'b0, a, b, c, d);
        measure(x, y, w, h);
        total++; if (x !== 316) begin bad++; $display("FAIL pause_x: got %0d want 316", x); end
        total++; if (y !== 240) begin bad++; $display("FAIL pause_y: got %0d want 240", y); end
        en = 1'b1;
        run_ticks(1);
        measure(x, y, w, h);
        total++; if (x !== 317 || y !== 241) begin bad++; $display("FAIL pause_resume: got %0d,%0d want 317,241", x, y); end
    endtask

    // Brings instance C to x = 1 heading left (speed 2).
    task automatic reach_left_edge();
        logic a, b, c, d;
        sel = 2; en = 1'b1;
        do_reset();
        run_ticks(2);
        do_tick(1'b1, a, b, c, d);
        run_ticks(156);
    endtask

    task automatic test_miss_left();
        int   x, y, w, h;
        logic l1, r1, l2, r2;
        reach_left_edge();
        measure(x, y, w, h);
        total++; if (x !== 1) begin bad++; $display("FAIL left_pre_x: got %0d want 1", x); end
        do_tick(1'b0, l1, r1, l2, r2);
        total++; if (l1 !== 1'b1) begin bad++; $display("FAIL miss_left_pulse: got %b want 1", l1); end
        total++; if (l2 !== 1'b0) begin bad++; $display("FAIL miss_left_one_cycle: got %b want 0", l2); end
        total++; if (r1 !== 1'b0) begin bad++; $display("FAIL miss_left_right_quiet: got %b want 0", r1); end
        total++; if (srv_s !== 1'b0) begin bad++; $display("FAIL miss_left_serving: got %b want 0", srv_s); end
        measure(x, y, w, h);
        total++; if (x !== -1) begin bad++; $display("FAIL miss_left_blank: got x %0d want -1", x); end
        run_ticks(1);
        total++; if (srv_s !== 1'b1) begin bad++; $display("FAIL miss_left_centre_serving: got %b want 1", srv_s); end
        run_ticks(1);
        measure(x, y, w, h);
        total++; if (x !== 315 || y !== 235) begin bad++; $display("FAIL miss_left_centre_pos: got %0d,%0d want 315,235", x, y); end
        run_ticks(2);
        measure(x, y, w, h);
        total++; if (x !== 313) begin bad++; $display("FAIL miss_left_serve_dir: got %0d want 313", x); end
    endtask

    task automatic test_race();
        int   x, y, w, h;
        logic l1, r1, l2, r2;
        reach_left_edge();
        hit_pulse();
        do_tick(1'b0, l1, r1, l2, r2);
        total++; if (l1 !== 1'b0) begin bad++; $display("FAIL race_no_miss_left: got %b want 0", l1); end
        total++; if (r1 !== 1'b0) begin bad++; $display("FAIL race_no_miss_right: got %b want 0", r1); end
        measure(x, y, w, h);
        total++; if (x !== 3) begin bad++; $display("FAIL race_x: got %0d want 3", x); end
        run_ticks(1);
        measure(x, y, w, h);
        total++; if (x !== 5) begin bad++; $display("FAIL race_follow_x: got %0d want 5", x); end
    endtask

    initial begin
        rst = 1'b0; hit = 1'b0; en = 1'b1; sel = 0;
        idle_pos();
        test_reset();
        test_serve_delay();
        test_bounce();
        test_miss_right();
        test_hit();
        test_pause();
        test_miss_left();
        test_race();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
